// File: rtl/wb_stage.sv
// Writeback stage: one register between MEM and the register file. Formats load
// data, drives the RF write port and commit record, and halts the core on ebreak.
module wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic [4:0]       in_rd,
  input  logic             in_rf_wen,
  input  logic             in_is_load,
  input  logic [2:0]       in_ld_type,
  input  logic [31:0]      in_alu_res,
  input  logic [31:0]      in_mem_rdata,
  input  logic             in_ebreak,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             cmt_valid,
  output logic [31:0]      cmt_pc,
  output logic [31:0]      cmt_inst,
  output logic             cmt_ebreak,
  output logic             halted,
  output logic [CNT_W-1:0] cmt_count
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;

  logic             r_vld_p1;
  logic [31:0]      r_pc_p1;
  logic [31:0]      r_inst_p1;
  logic [4:0]       r_rd_p1;
  logic             r_rf_wen_p1;
  logic             r_is_load_p1;
  logic [2:0]       r_ld_type_p1;
  logic [31:0]      r_alu_res_p1;
  logic [31:0]      r_mem_rdata_p1;
  logic             r_ebreak_p1;
  logic [CNT_W-1:0] r_cnt;

  // Lane extraction on the aligned word; halfword lane ignores addr[0].
  function automatic logic [31:0] fmt_load(input logic [2:0]  ld_type,
                                           input logic [1:0]  addr,
                                           input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b   = signed'(word[8*addr +: 8]);
    h   = signed'(addr[1] ? word[31:16] : word[15:0]);
    res = word;
    case (ld_type)
      3'b000:  res = 32'(b);
      3'b001:  res = 32'(h);
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign in_ready = (r_state == S_RUN) && !(r_vld_p1 && r_ebreak_p1);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RUN && cmt_valid && cmt_ebreak)
      w_state_nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // ---- stage p1: held retiring instruction ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1       <= 1'b0;
      r_pc_p1        <= '0;
      r_inst_p1      <= '0;
      r_rd_p1        <= '0;
      r_rf_wen_p1    <= 1'b0;
      r_is_load_p1   <= 1'b0;
      r_ld_type_p1   <= '0;
      r_alu_res_p1   <= '0;
      r_mem_rdata_p1 <= '0;
      r_ebreak_p1    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_pc_p1        <= in_pc;
        r_inst_p1      <= in_inst;
        r_rd_p1        <= in_rd;
        r_rf_wen_p1    <= in_rf_wen;
        r_is_load_p1   <= in_is_load;
        r_ld_type_p1   <= in_ld_type;
        r_alu_res_p1   <= in_alu_res;
        r_mem_rdata_p1 <= in_mem_rdata;
        r_ebreak_p1    <= in_ebreak;
      end
      if (cmt_valid)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cmt_valid  = r_vld_p1;
  assign cmt_pc     = r_pc_p1;
  assign cmt_inst   = r_inst_p1;
  assign cmt_ebreak = r_ebreak_p1;
  assign cmt_count  = r_cnt;
  assign halted     = (r_state == S_HALT);
  assign rf_wen     = r_vld_p1 && r_rf_wen_p1 && (r_rd_p1 != 5'd0) && !r_ebreak_p1;
  assign rf_waddr   = r_rd_p1;
  assign rf_wdata   = r_is_load_p1 ? fmt_load(r_ld_type_p1, r_alu_res_p1[1:0], r_mem_rdata_p1)
                                   : r_alu_res_p1;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes hand-computed commit records,
// a negedge monitor pops and compares whenever cmt_valid is presented.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_inst, in_alu_res, in_mem_rdata;
  logic [4:0]  in_rd;
  logic        in_rf_wen, in_is_load, in_ebreak;
  logic [2:0]  in_ld_type;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cmt_valid;
  logic [31:0] cmt_pc, cmt_inst;
  logic        cmt_ebreak, halted;
  logic [63:0] cmt_count;

  wb_stage #(.CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .in_is_load(in_is_load), .in_ld_type(in_ld_type), .in_alu_res(in_alu_res),
    .in_mem_rdata(in_mem_rdata), .in_ebreak(in_ebreak),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
    .cmt_ebreak(cmt_ebreak), .halted(halted), .cmt_count(cmt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ebrk;
    logic [63:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every presented commit must match the oldest outstanding record.
  always @(negedge clk) begin
    if (cmt_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_commit_pc", cmt_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rf_wen",     rf_wen,     e.wen);
        chk("rf_waddr",   rf_waddr,   e.waddr);
        chk("rf_wdata",   rf_wdata,   e.wdata);
        chk("cmt_pc",     cmt_pc,     e.pc);
        chk("cmt_inst",   cmt_inst,   e.inst);
        chk("cmt_ebreak", cmt_ebreak, e.ebrk);
        chk("cmt_count",  cmt_count,  e.cnt);
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_inst = 0; in_rd = 0; in_rf_wen = 0;
    in_is_load = 0; in_ld_type = 0; in_alu_res = 0; in_mem_rdata = 0; in_ebreak = 0;
  endtask

  // Drive one instruction for one cycle; push the expected record if accepted.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                       input logic wen, input logic isld, input logic [2:0] ldt,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic ebrk,
                       input logic [31:0] exp_wdata, input logic exp_rdy);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1; in_pc = pc; in_inst = inst; in_rd = rd; in_rf_wen = wen;
    in_is_load = isld; in_ld_type = ldt; in_alu_res = alu; in_mem_rdata = rdata;
    in_ebreak = ebrk;
    chk("in_ready", in_ready, exp_rdy);
    if (in_ready) begin
      e.wen = wen && (rd != 0) && !ebrk; e.waddr = rd; e.wdata = exp_wdata;
      e.pc = pc; e.inst = inst; e.ebrk = ebrk; e.cnt = exp_cnt;
      q.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rf_wen"},     rf_wen,     0);
    chk({tag, "_rf_waddr"},   rf_waddr,   0);
    chk({tag, "_rf_wdata"},   rf_wdata,   0);
    chk({tag, "_cmt_valid"},  cmt_valid,  0);
    chk({tag, "_cmt_pc"},     cmt_pc,     0);
    chk({tag, "_cmt_inst"},   cmt_inst,   0);
    chk({tag, "_cmt_ebreak"}, cmt_ebreak, 0);
    chk({tag, "_halted"},     halted,     0);
    chk({tag, "_in_ready"},   in_ready,   1);
    chk({tag, "_cmt_count"},  cmt_count,  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] W = 32'h80FF7F01;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    check_reset_state("reset");

    // addi x5, x0, 5
    issue(32'h80000000, 32'h00500293, 5, 1, 0, 3'b000, 32'd5, 0, 0, 32'd5, 1);
    idle_cycle();
    idle_cycle();
    chk("count_after_addi", cmt_count, 1);

    // Load formatting on 0x80FF7F01
    issue(32'h80000004, 32'h00000003, 6,  1, 1, 3'b000, 32'h1001, W, 0, 32'h0000007F, 1);
    issue(32'h80000008, 32'h00000003, 7,  1, 1, 3'b000, 32'h1003, W, 0, 32'hFFFFFF80, 1);
    issue(32'h8000000C, 32'h00000003, 8,  1, 1, 3'b101, 32'h1002, W, 0, 32'h000080FF, 1);
    issue(32'h80000010, 32'h00000003, 9,  1, 1, 3'b001, 32'h1003, W, 0, 32'hFFFF80FF, 1);
    issue(32'h80000014, 32'h00000003, 10, 1, 1, 3'b100, 32'h1003, W, 0, 32'h00000080, 1);
    issue(32'h80000018, 32'h00000003, 11, 1, 1, 3'b001, 32'h1000, W, 0, 32'h00007F01, 1);
    issue(32'h8000001C, 32'h00000003, 12, 1, 1, 3'b010, 32'h1000, W, 0, 32'h80FF7F01, 1);
    issue(32'h80000020, 32'h00000003, 13, 1, 1, 3'b011, 32'h1001, W, 0, 32'h80FF7F01, 1);
    // rd = 0 suppresses the write but still commits
    issue(32'h80000024, 32'h00000013, 0,  1, 0, 3'b000, 32'h1234, 0, 0, 32'h00001234, 1);
    idle_cycle();
    idle_cycle();
    chk("count_after_loads", cmt_count, 10);

    // Fresh run: 4 back-to-back instructions
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0; exp_cnt = 0;
    check_reset_state("reset2");
    for (int i = 0; i < 4; i++)
      issue(32'h80000100 + 4*i, 32'h00100093 + i, 5'(i + 1), 1, 0, 3'b000,
            32'hA0 + i, 0, 0, 32'hA0 + i, 1);
    idle_cycle();
    idle_cycle();
    chk("count_b2b", cmt_count, 4);
    chk("queue_drained_b2b", q.size(), 0);

    // ebreak followed by continuous in_valid
    issue(32'h80000200, 32'h00100073, 1, 1, 0, 3'b000, 32'h55, 0, 1, 32'h55, 1);
    issue(32'h80000204, 32'h00000013, 2, 1, 0, 3'b000, 32'h66, 0, 0, 32'h66, 0);
    chk("ebreak_cycle_cmt_ebreak", cmt_ebreak, 1);
    chk("ebreak_cycle_rf_wen", rf_wen, 0);
    for (int i = 0; i < 4; i++) begin
      issue(32'h80000208 + 4*i, 32'h00000013, 3, 1, 0, 3'b000, 32'h77, 0, 0, 32'h77, 0);
      chk("halted", halted, 1);
      chk("halt_no_commit", cmt_valid, 0);
      chk("halt_count_frozen", cmt_count, exp_cnt);
    end

    // Reset while halted
    @(posedge clk); #1; rst = 1; in_valid = 1;
    @(posedge clk); #1; rst = 0; idle_inputs(); exp_cnt = 0;
    check_reset_state("reset_halted");

    // Reset while an instruction is held; the instruction offered on the reset edge is dropped
    issue(32'h80000300, 32'h00700393, 7, 1, 0, 3'b000, 32'h7, 0, 0, 32'h7, 1);
    @(posedge clk); #1;
    rst = 1; in_valid = 1; in_pc = 32'h80000304; in_rd = 8; in_rf_wen = 1; in_alu_res = 32'h99;
    @(posedge clk); #1; rst = 0; idle_inputs(); exp_cnt = 0;
    check_reset_state("reset_held");
    idle_cycle();
    chk("dropped_no_commit", cmt_valid, 0);
    chk("queue_drained_end", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
